uart_mem_loader: RTL and testbench
==================================

# uart_mem_loader

Command responder on the byte side of the UART. It parses host frames from the receive path into 16-bit memory writes and reads, and returns read data and acknowledgements over the transmit path. It sits between the UART and the ROM/RAM write ports, and is used to load and inspect program memory over the serial line while the CPU is held in reset.

## Interface
Parameters:
- ADDR_W, 15 — memory address width; 16-bit frame address is truncated to the low ADDR_W bits
- TIMEOUT_CYCLES, 1_000_000 — maximum clk cycles between bytes of one frame; 24-bit counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle pulse: byte received (UART `received`)
- rx_byte  in  8  received byte, valid when rx_valid=1
- rx_error  in  1  one-cycle pulse: framing error
- tx_busy  in  1  UART transmitter busy (`is_transmitting`)
- tx_start  out  1  one-cycle pulse: send tx_byte
- tx_byte  out  8  byte to send; held stable from tx_start until tx_busy falls
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  16  read data, valid exactly 1 cycle after mem_re
- active  out  1  high from first frame byte until frame fully completed (response sent)

## Operation
- Frame formats, big-endian:
  - write: 0x57 ('W'), A_hi, A_lo, D_hi, D_lo
  - read: 0x52 ('R'), A_hi, A_lo; response D_hi, D_lo
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WRITE, READ, CAPTURE, SEND, WAIT_TX.
- IDLE, on rx_valid:
  - 0x57 or 0x52: latch the opcode, go to ADDR_HI.
  - Any other byte: go to the NAK path (see Configuration), else stay in IDLE.
- ADDR_HI → ADDR_LO, on rx_valid.
- ADDR_LO exit:
  - 'W': → DATA_HI → DATA_LO, each on rx_valid.
  - 'R': → READ.
- WRITE: mem_we=1 for one cycle, then the ACK path or IDLE.
- READ: mem_re=1 for one cycle.
- CAPTURE: register mem_rdata, load a 2-byte send queue (D_hi first).
- SEND: drives tx_start=1 for one cycle, only when tx_busy=0.
- WAIT_TX:
  - Waits until tx_busy has been seen high and then low.
  - Then sends the next queued byte, or returns to IDLE when the queue is empty.
- Address/data shift registers load only on rx_valid in the matching state.
- mem_addr and mem_wdata hold their last value between frames.
- Abort to IDLE with no memory access and no response when either occurs during ADDR_HI..DATA_LO:
  - rx_error, or
  - timeout: counter reaches TIMEOUT_CYCLES with no rx_valid; the counter clears on each rx_valid.
- rx_valid while in WRITE/READ/CAPTURE/SEND/WAIT_TX is dropped; it is not queued.
- The timeout counter does not run in IDLE or in any transmit state.

## Timing
- Reset values: tx_start=0, tx_byte=0x00, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, active=0, state IDLE, queue empty.
- Reset mid-frame or mid-transmit returns to IDLE the following cycle and drops the queue.
- Write: mem_we is high in the cycle after the rx_valid of D_lo; mem_addr and mem_wdata are already stable in that cycle.
- Read: mem_re is high the cycle after the rx_valid of A_lo. Data is captured on the next edge. tx_start for D_hi follows 1 cycle later if tx_busy=0.
- tx_start is never asserted in two consecutive cycles, and never while tx_busy=1.
- active rises on the cycle following the opcode rx_valid. It falls when the state returns to IDLE.

## Configuration
- UART_MEM_LOADER_ACK_EN:
  - Defined:
    - Each completed write queues one byte 0x06 (ACK), sent via SEND/WAIT_TX.
    - An unknown opcode in IDLE queues 0x15 (NAK).
    - active stays high until the ACK/NAK has finished transmitting.
  - Undefined:
    - Writes are silent; WRITE returns directly to IDLE.
    - Unknown opcodes are silently discarded.
    - Read responses are unaffected either way.

## Test plan
- Write 0x57 0x00 0x10 0xBE 0xEF:
  - mem_we pulses once with mem_addr=0x0010, mem_wdata=0xBEEF.
  - With ACK_EN, tx sends 0x06; without it, no tx.
- Read 0x52 0x00 0x10, RAM model returning 0xBEEF:
  - mem_re pulses once with mem_addr=0x0010.
  - tx sends 0xBE then 0xEF; tx_start is never asserted while tx_busy=1.
- Address truncation: write 0x57 0xFF 0xFF 0x12 0x34 with ADDR_W=15 → mem_addr=0x7FFF, mem_wdata=0x1234.
- Abort, two cases, each followed by a valid write that must then succeed:
  - rx_error after A_hi → no mem_we, no tx, active=0.
  - TIMEOUT_CYCLES=100, stall 101 cycles after A_lo → same abort behaviour.
- Unknown opcode 0x41:
  - ACK_EN: tx 0x15.
  - Otherwise: no tx, and state stays IDLE.
  - Bytes sent during read-response transmission are dropped.
- rst asserted mid read-response:
  - Next cycle: all outputs at their reset values.
  - A new read frame afterwards completes correctly.

Source files
------------

// File: rtl/uart_mem_loader.sv
// Purpose : UART byte-stream command responder; 'W' A_hi A_lo D_hi D_lo writes one
//           16-bit word, 'R' A_hi A_lo reads one word and returns D_hi, D_lo.
// Latency : mem_we / mem_re one cycle after the final frame byte; read data is
//           captured the cycle after mem_re and the first tx_start follows SEND.
// Backpressure: none on rx (bytes arriving while busy are dropped); tx waits on tx_busy.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_valid/rx_byte/rx_error UART receive side (one-cycle pulses)
//   tx_busy/tx_start/tx_byte  UART transmit side
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata  word-wide memory port (rdata 1 cycle after re)
//   active                    high while a frame is in progress, including its response
//
// Build option: define UART_MEM_LOADER_ACK_EN to answer writes with 0x06 and unknown
// opcodes with 0x15; without it writes are silent and unknown opcodes are discarded.

module uart_mem_loader #(
    parameter int ADDR_W         = 15,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_error,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic              active
);

    localparam logic [7:0]  OP_WRITE = 8'h57;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [23:0] TMO_MAX  = 24'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t              state_q, state_d;
    logic                op_rd_q, op_rd_d;
    logic [7:0]          addr_hi_q, addr_hi_d;
    logic [7:0]          data_hi_q, data_hi_d;
    logic [23:0]         tmo_cnt_q, tmo_cnt_d;
    logic [15:0]         q_dat_q, q_dat_d;      // send queue, head byte in [15:8]
    logic [1:0]          q_cnt_q, q_cnt_d;
    logic                seen_busy_q, seen_busy_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                active_q, active_d;

    logic                in_frame;
    logic                abort;
    logic [15:0]         full_addr;

    assign full_addr = {addr_hi_q, rx_byte};
    assign in_frame  = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
                       (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    // An error pulse wins over a byte arriving in the same cycle.
    assign abort     = in_frame && (rx_error || (!rx_valid && (tmo_cnt_q >= TMO_MAX)));

    always_comb begin
        state_d     = state_q;
        op_rd_d     = op_rd_q;
        addr_hi_d   = addr_hi_q;
        data_hi_d   = data_hi_q;
        tmo_cnt_d   = 24'd0;
        q_dat_d     = q_dat_q;
        q_cnt_d     = q_cnt_q;
        seen_busy_d = seen_busy_q;
        tx_start_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;

        // Inter-byte timer only runs while collecting frame bytes.
        if (in_frame && !abort) begin
            tmo_cnt_d = rx_valid ? 24'd0 : tmo_cnt_q + 24'd1;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                            op_rd_d = (rx_byte == OP_READ);
                            state_d = S_ADDR_HI;
                        end else begin
`ifdef UART_MEM_LOADER_ACK_EN
                            q_dat_d = {8'h15, 8'h00};
                            q_cnt_d = 2'd1;
                            state_d = S_SEND;
`endif
                        end
                    end
                end
                S_ADDR_HI: begin
                    if (rx_valid) begin
                        addr_hi_d = rx_byte;
                        state_d   = S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (rx_valid) begin
                        mem_addr_d = full_addr[ADDR_W-1:0];
                        if (op_rd_q) begin
                            mem_re_d = 1'b1;
                            state_d  = S_READ;
                        end else begin
                            state_d  = S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (rx_valid) begin
                        data_hi_d = rx_byte;
                        state_d   = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (rx_valid) begin
                        mem_wdata_d = {data_hi_q, rx_byte};
                        mem_we_d    = 1'b1;
                        state_d     = S_WRITE;
                    end
                end
                S_WRITE: begin
`ifdef UART_MEM_LOADER_ACK_EN
                    q_dat_d = {8'h06, 8'h00};
                    q_cnt_d = 2'd1;
                    state_d = S_SEND;
`else
                    state_d = S_IDLE;
`endif
                end
                S_READ: begin
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    q_dat_d = mem_rdata;
                    q_cnt_d = 2'd2;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start_d  = 1'b1;
                        tx_byte_d   = q_dat_q[15:8];
                        q_dat_d     = {q_dat_q[7:0], 8'h00};
                        q_cnt_d     = q_cnt_q - 2'd1;
                        seen_busy_d = 1'b0;
                        state_d     = S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    // A byte is done only after the UART has gone busy and then idle again.
                    if (tx_busy) begin
                        seen_busy_d = 1'b1;
                    end else if (seen_busy_q) begin
                        state_d = (q_cnt_q != 2'd0) ? S_SEND : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_rd_q     <= 1'b0;
            addr_hi_q   <= 8'h00;
            data_hi_q   <= 8'h00;
            tmo_cnt_q   <= 24'd0;
            q_dat_q     <= 16'h0000;
            q_cnt_q     <= 2'd0;
            seen_busy_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_rd_q     <= op_rd_d;
            addr_hi_q   <= addr_hi_d;
            data_hi_q   <= data_hi_d;
            tmo_cnt_q   <= tmo_cnt_d;
            q_dat_q     <= q_dat_d;
            q_cnt_q     <= q_cnt_d;
            seen_busy_q <= seen_busy_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            active_q    <= active_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_byte   = tx_byte_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign active    = active_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Purpose : self-checking bench for uart_mem_loader (UART, RAM and host modelled here).
// Latency : checks mem_we / mem_re exactly one cycle after the last frame byte.
// Backpressure: UART model holds tx_busy for a random 3..10 cycles per byte.

module tb_uart_mem_loader;

    localparam int ADDR_W = 15;
    localparam int TMO    = 100;
`ifdef UART_MEM_LOADER_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_error = 1'b0;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata = 16'h0000;
    logic              active;

    uart_mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .active(active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    logic rst_seen = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Physical RAM behind the DUT and the bench's own expected memory image.
    logic [15:0] ram   [0:32767];
    logic [15:0] model [0:32767];

    // Observation queues filled by the monitor.
    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] we_addr_q[$];
    logic [15:0]       we_data_q[$];
    int                we_cyc_q[$];
    logic [ADDR_W-1:0] re_addr_q[$];
    int                re_cyc_q[$];
    int v_busy = 0, v_consec = 0, v_hold = 0;

    logic        prev_re = 1'b0;
    logic [15:0] rd_val = 16'h0000;
    logic        prev_start = 1'b0;
    int          busy_cnt = 0;
    logic [7:0]  held = 8'h00;
    bit          hold_en = 1'b0;

    // RAM, UART transmitter and protocol monitor, all sampled on the falling edge.
    always @(negedge clk) begin
        mem_rdata = prev_re ? rd_val : 16'($urandom);
        prev_re   = 1'b0;
        if (mem_re === 1'b1) begin
            rd_val  = ram[mem_addr];
            prev_re = 1'b1;
            re_addr_q.push_back(mem_addr);
            re_cyc_q.push_back(cyc);
        end
        if (mem_we === 1'b1) begin
            ram[mem_addr] = mem_wdata;
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
            we_cyc_q.push_back(cyc);
        end
        if (rst_seen) hold_en = 1'b0;
        if (tx_start === 1'b1) begin
            if (tx_busy) v_busy++;
            if (prev_start) v_consec++;
            tx_q.push_back(tx_byte);
            held     = tx_byte;
            hold_en  = 1'b1;
            busy_cnt = $urandom_range(3, 10);
            tx_busy  = 1'b1;
        end else if (tx_busy) begin
            if (hold_en && tx_byte !== held) v_hold++;
            if (busy_cnt == 0) tx_busy = 1'b0;
            else busy_cnt--;
        end
        prev_start = (tx_start === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte = b;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_write(input logic [15:0] a, input logic [15:0] d, input int g);
        send_byte(8'h57); gap(g);
        send_byte(a[15:8]); gap(g);
        send_byte(a[7:0]); gap(g);
        send_byte(d[15:8]); gap(g);
        send_byte(d[7:0]);
    endtask

    task automatic send_read(input logic [15:0] a, input int g);
        send_byte(8'h52); gap(g);
        send_byte(a[15:8]); gap(g);
        send_byte(a[7:0]);
    endtask

    task automatic clear_obs();
        tx_q.delete();
        we_addr_q.delete(); we_data_q.delete(); we_cyc_q.delete();
        re_addr_q.delete(); re_cyc_q.delete();
    endtask

    // Bounded wait until the frame and any transmission have finished.
    task automatic wait_done(input string name);
        int n = 0;
        while ((active !== 1'b0 || tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_done: active=%b still after %0d cycles, required 0", name, active, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        gap(3);
        checks += 7;
        if (tx_start !== 1'b0)    begin errors++; $display("FAIL rst_tx_start: got %b required 0", tx_start); end
        if (tx_byte !== 8'h00)    begin errors++; $display("FAIL rst_tx_byte: got %h required 00", tx_byte); end
        if (mem_addr !== '0)      begin errors++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        if (mem_wdata !== 16'h0)  begin errors++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        if (mem_we !== 1'b0)      begin errors++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        if (mem_re !== 1'b0)      begin errors++; $display("FAIL rst_mem_re: got %b required 0", mem_re); end
        if (active !== 1'b0)      begin errors++; $display("FAIL rst_active: got %b required 0", active); end
        rst = 1'b0;
        gap(3);
        checks++;
        if (active !== 1'b0 || tx_start !== 1'b0) begin
            errors++; $display("FAIL post_rst_idle: active=%b tx_start=%b required 0 0", active, tx_start);
        end
    endtask

    task automatic test_write();
        logic [15:0] wa[$];
        logic [15:0] wd[$];
        wa.push_back(16'h0010); wd.push_back(16'hBEEF);
        wa.push_back(16'hFFFF); wd.push_back(16'h1234);   // truncates to 0x7FFF
        for (int i = 0; i < 10; i++) begin
            wa.push_back(16'($urandom)); wd.push_back(16'($urandom));
        end
        for (int i = 0; i < wa.size(); i++) begin
            logic [14:0] ea;
            ea = wa[i][14:0];
            clear_obs();
            send_write(wa[i], wd[i], $urandom_range(0, 4));
            wait_done("write");
            model[ea] = wd[i];
            checks++;
            if (we_addr_q.size() != 1) begin
                errors++; $display("FAIL write_we_count[%0d]: got %0d pulses required 1", i, we_addr_q.size());
            end else begin
                checks += 3;
                if (we_addr_q[0] !== ea) begin
                    errors++; $display("FAIL write_addr[%0d]: got %h required %h", i, we_addr_q[0], ea);
                end
                if (we_data_q[0] !== wd[i]) begin
                    errors++; $display("FAIL write_data[%0d]: got %h required %h", i, we_data_q[0], wd[i]);
                end
                if (we_cyc_q[0] != last_rx_cyc + 1) begin
                    errors++; $display("FAIL write_timing[%0d]: we at cycle %0d required %0d", i, we_cyc_q[0], last_rx_cyc + 1);
                end
            end
            checks++;
            if (tx_q.size() != (ACK ? 1 : 0)) begin
                errors++; $display("FAIL write_tx_count[%0d]: got %0d bytes required %0d", i, tx_q.size(), ACK ? 1 : 0);
            end else if (ACK) begin
                checks++;
                if (tx_q[0] !== 8'h06) begin errors++; $display("FAIL write_ack[%0d]: got %h required 06", i, tx_q[0]); end
            end
            gap($urandom_range(0, 3));
        end
    endtask

    task automatic test_read();
        logic [15:0] ra[$];
        ra.push_back(16'h0010);
        ra.push_back(16'hFFFF);
        for (int i = 0; i < 8; i++) ra.push_back(16'($urandom));
        for (int i = 0; i < ra.size(); i++) begin
            logic [14:0] ea;
            logic [15:0] ed;
            ea = ra[i][14:0];
            ed = model[ea];
            clear_obs();
            send_read(ra[i], $urandom_range(0, 4));
            wait_done("read");
            checks++;
            if (re_addr_q.size() != 1) begin
                errors++; $display("FAIL read_re_count[%0d]: got %0d pulses required 1", i, re_addr_q.size());
            end else begin
                checks += 2;
                if (re_addr_q[0] !== ea) begin
                    errors++; $display("FAIL read_addr[%0d]: got %h required %h", i, re_addr_q[0], ea);
                end
                if (re_cyc_q[0] != last_rx_cyc + 1) begin
                    errors++; $display("FAIL read_timing[%0d]: re at cycle %0d required %0d", i, re_cyc_q[0], last_rx_cyc + 1);
                end
            end
            checks++;
            if (tx_q.size() != 2) begin
                errors++; $display("FAIL read_tx_count[%0d]: got %0d bytes required 2", i, tx_q.size());
            end else begin
                checks++;
                if (tx_q[0] !== ed[15:8] || tx_q[1] !== ed[7:0]) begin
                    errors++; $display("FAIL read_data[%0d]: got %h%h required %h", i, tx_q[0], tx_q[1], ed);
                end
            end
            checks++;
            if (we_addr_q.size() != 0) begin errors++; $display("FAIL read_no_we[%0d]: got %0d writes required 0", i, we_addr_q.size()); end
            gap($urandom_range(0, 3));
        end
    endtask

    // case 0: rx_error after A_hi; case 1: stall past timeout after A_lo;
    // case 2: long gap below the limit must still complete the write.
    task automatic test_abort();
        for (int c = 0; c < 3; c++) begin
            logic [15:0] a, d;
            clear_obs();
            d = 16'($urandom);
            if (c == 0) begin
                send_byte(8'h57); send_byte(8'h00);
                @(negedge clk); rx_error = 1'b1;
                @(negedge clk); rx_error = 1'b0;
                gap(2);
            end else if (c == 1) begin
                send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
                gap(TMO + 10);
            end else begin
                send_byte(8'h57); send_byte(8'h00); send_byte(8'h21);
                gap(TMO / 2);
                send_byte(d[15:8]); send_byte(d[7:0]);
                wait_done("gap_write");
                model[15'h0021] = d;
            end
            checks++;
            if (active !== 1'b0) begin errors++; $display("FAIL abort_active[%0d]: got %b required 0", c, active); end
            checks++;
            if (we_addr_q.size() != (c == 2 ? 1 : 0)) begin
                errors++; $display("FAIL abort_we_count[%0d]: got %0d required %0d", c, we_addr_q.size(), c == 2 ? 1 : 0);
            end
            checks++;
            if (tx_q.size() != ((c == 2 && ACK) ? 1 : 0)) begin
                errors++; $display("FAIL abort_tx_count[%0d]: got %0d bytes", c, tx_q.size());
            end
            // A normal write afterwards must go through.
            clear_obs();
            a = 16'h0030 + 16'(c);
            d = 16'($urandom);
            send_write(a, d, 1);
            wait_done("abort_recover");
            model[a[14:0]] = d;
            checks++;
            if (we_addr_q.size() != 1 || we_addr_q[0] !== a[14:0] || we_data_q[0] !== d) begin
                errors++; $display("FAIL abort_recover[%0d]: got %0d writes, required one of %h to %h", c, we_addr_q.size(), d, a[14:0]);
            end
        end
    endtask

    task automatic test_unknown();
        logic [7:0] ops[$];
        ops.push_back(8'h41);
        while (ops.size() < 4) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b != 8'h57 && b != 8'h52) ops.push_back(b);
        end
        foreach (ops[i]) begin
            clear_obs();
            send_byte(ops[i]);
            checks++;
            if (active !== ACK) begin errors++; $display("FAIL unk_active[%0d]: got %b required %b", i, active, ACK); end
            wait_done("unknown");
            gap(3);
            checks++;
            if (tx_q.size() != (ACK ? 1 : 0)) begin
                errors++; $display("FAIL unk_tx_count[%0d]: got %0d required %0d", i, tx_q.size(), ACK ? 1 : 0);
            end else if (ACK) begin
                checks++;
                if (tx_q[0] !== 8'h15) begin errors++; $display("FAIL unk_nak[%0d]: got %h required 15", i, tx_q[0]); end
            end
            checks++;
            if (we_addr_q.size() + re_addr_q.size() != 0) begin
                errors++; $display("FAIL unk_mem[%0d]: got %0d accesses required 0", i, we_addr_q.size() + re_addr_q.size());
            end
        end
    endtask

    task automatic test_drop_during_tx();
        int n = 0;
        int sent = 0;
        clear_obs();
        send_read(16'h0010, 0);
        // Keep pushing 'W' bytes while the response is still going out.
        while (active === 1'b1 && n < 200) begin
            send_byte(8'h57);
            sent++;
            n++;
        end
        wait_done("drop");
        gap(5);
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== model[15'h0010][15:8] || tx_q[1] !== model[15'h0010][7:0]) begin
            errors++; $display("FAIL drop_tx: got %0d bytes, required %h after %0d dropped", tx_q.size(), model[15'h0010], sent);
        end
        checks++;
        if (we_addr_q.size() != 0) begin errors++; $display("FAIL drop_no_write: got %0d writes required 0", we_addr_q.size()); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL drop_idle: active=%b required 0", active); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [15:0] ed;
        clear_obs();
        send_read(16'h7FFF, 0);
        while (tx_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (tx_q.size() == 0) begin errors++; $display("FAIL rmid_first_byte: no tx_start within %0d cycles", n); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks += 7;
        if (tx_start !== 1'b0)   begin errors++; $display("FAIL rmid_tx_start: got %b required 0", tx_start); end
        if (tx_byte !== 8'h00)   begin errors++; $display("FAIL rmid_tx_byte: got %h required 00", tx_byte); end
        if (mem_addr !== '0)     begin errors++; $display("FAIL rmid_mem_addr: got %h required 0", mem_addr); end
        if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rmid_mem_wdata: got %h required 0", mem_wdata); end
        if (mem_we !== 1'b0)     begin errors++; $display("FAIL rmid_mem_we: got %b required 0", mem_we); end
        if (mem_re !== 1'b0)     begin errors++; $display("FAIL rmid_mem_re: got %b required 0", mem_re); end
        if (active !== 1'b0)     begin errors++; $display("FAIL rmid_active: got %b required 0", active); end
        rst = 1'b0;
        wait_done("rmid_drain");
        gap(20);
        checks++;
        if (tx_q.size() != 1) begin errors++; $display("FAIL rmid_queue_dropped: got %0d bytes required 1", tx_q.size()); end
        clear_obs();
        ed = model[15'h0021];
        send_read(16'h0021, 1);
        wait_done("rmid_read");
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== ed[15:8] || tx_q[1] !== ed[7:0]) begin
            errors++; $display("FAIL rmid_read_after: got %0d bytes required %h", tx_q.size(), ed);
        end
    endtask

    task automatic test_tx_protocol();
        checks += 3;
        if (v_busy != 0)   begin errors++; $display("FAIL tx_while_busy: got %0d required 0", v_busy); end
        if (v_consec != 0) begin errors++; $display("FAIL tx_back_to_back: got %0d required 0", v_consec); end
        if (v_hold != 0)   begin errors++; $display("FAIL tx_byte_hold: got %0d changes required 0", v_hold); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]   = 16'(i * 37 + 5);
            model[i] = 16'(i * 37 + 5);
        end
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_unknown();
        test_drop_during_tx();
        test_reset_mid();
        test_tx_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
